// File: rtl/gps_pps_tracker.sv
// Disciplined 64-bit fractional-second counter, phase-locked to an external GPS PPS
// through a proportional + integral loop; emits a local PPS on every counter wrap.
//
// state   | meaning
// ACQUIRE | free-running; the next GPS edge hard-aligns the counter to zero phase
// TRACK   | each GPS edge measures phase error and steers count and step

module gps_pps_tracker #(
    parameter int            RW           = 64,
    parameter logic [RW-1:0] DEFAULT_STEP = RW'(64'h0000_0034_e3d7_0a3d),
    parameter int            ALPHA_SHIFT  = 8,
    parameter int            BETA_SHIFT   = 16,
    parameter logic [RW-1:0] LOCK_THRESH  = RW'(64'h0010_0000_0000_0000),
    parameter int            LOCK_COUNT   = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_gps_pps,
    input  logic          i_ld_step,
    input  logic [RW-1:0] i_step_val,
    output logic          o_lcl_pps,
    output logic [RW-1:0] o_count,
    output logic [RW-1:0] o_step,
    output logic [RW-1:0] o_err,
    output logic          o_err_stb,
    output logic          o_locked
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] LOCK_CNT_V = GW'(LOCK_COUNT);
    localparam logic [RW-1:0] MOST_NEG   = {1'b1, {(RW-1){1'b0}}};

    typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [2:0]         sync_q;
    logic               gps_edge;
    logic               pending;
    logic [GW-1:0]      good_cnt, good_inc;
    logic [1:0]         miss_cnt;
    logic               edge_v, acq_load, trk_edge, miss_inc, drop;
    logic signed [RW-1:0] err_s;
    logic [RW-1:0]      alpha_corr, beta_corr, err_mag;
    logic [RW+1:0]      sum;
    logic               carry, good_ok;

    // Two synchroniser flops, one history flop, registered rising-edge pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q   <= 3'b000;
            gps_edge <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], i_gps_pps};
            gps_edge <= sync_q[1] & ~sync_q[2];
        end
    end

    assign edge_v     = gps_edge & ~pending;
    assign err_s      = o_err;
    assign alpha_corr = err_s >>> ALPHA_SHIFT;
    assign beta_corr  = err_s >>> BETA_SHIFT;
    assign err_mag    = o_err[RW-1] ? ({RW{1'b0}} - o_err) : o_err;
    assign good_ok    = (err_mag < LOCK_THRESH) && (o_err != MOST_NEG);
    assign good_inc   = (good_cnt == LOCK_CNT_V) ? good_cnt : good_cnt + 1'b1;

    // Two guard bits: bit RW is the wrap, bit RW+1 flags a negative corrected sum.
    always_comb begin
        sum = {2'b00, o_count} + {2'b00, o_step};
        if (pending) begin
            sum = sum + {{2{alpha_corr[RW-1]}}, alpha_corr};
        end
    end

    assign carry = sum[RW] & ~sum[RW+1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ACQUIRE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACQUIRE: if (edge_v) state_nxt = TRACK;
            TRACK:   if (drop)   state_nxt = ACQUIRE;
        endcase
    end

    always_comb begin
        acq_load = 1'b0;
        trk_edge = 1'b0;
        miss_inc = 1'b0;
        drop     = 1'b0;
        case (state)
            ACQUIRE: acq_load = edge_v;
            TRACK: begin
                trk_edge = edge_v;
                miss_inc = carry & ~edge_v;
                drop     = miss_inc & (miss_cnt == 2'd1);
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_count   <= '0;
            o_step    <= DEFAULT_STEP;
            o_err     <= '0;
            o_err_stb <= 1'b0;
            o_lcl_pps <= 1'b0;
            o_locked  <= 1'b0;
            good_cnt  <= '0;
            miss_cnt  <= 2'd0;
            pending   <= 1'b0;
        end else begin
            pending   <= trk_edge;
            o_err_stb <= trk_edge;

            if (acq_load) begin
                o_count   <= o_step;
                o_lcl_pps <= 1'b1;
            end else begin
                o_count   <= sum[RW-1:0];
                o_lcl_pps <= carry;
            end

            if (trk_edge) begin
                o_err <= {RW{1'b0}} - o_count;
            end

            if (acq_load || trk_edge) begin
                miss_cnt <= 2'd0;
            end else if (miss_inc) begin
                miss_cnt <= miss_cnt + 2'd1;
            end

            // A software step load always wins over the loop's frequency update.
            if (i_ld_step) begin
                o_step <= i_step_val;
            end else if (pending) begin
                o_step <= o_step + beta_corr;
            end

            if (i_ld_step || acq_load || drop) begin
                good_cnt <= '0;
                o_locked <= 1'b0;
            end else if (pending) begin
                if (good_ok) begin
                    good_cnt <= good_inc;
                    o_locked <= (good_inc == LOCK_CNT_V);
                end else begin
                    good_cnt <= '0;
                    o_locked <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gps_pps_tracker.sv
// Bench for gps_pps_tracker: directed loop scenarios plus random GPS timing and step
// loads, compared every cycle against an event-level reference model.

module tb_gps_pps_tracker;

    localparam logic [63:0] STEP0  = 64'h1000_0000_0000_0000;
    localparam int          A_SH   = 8;
    localparam int          B_SH   = 16;
    localparam logic [63:0] THRESH = 64'h0010_0000_0000_0000;
    localparam int          LCNT   = 4;
    localparam logic signed [127:0] TWO64 = 128'sh1_0000_0000_0000_0000;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_gps_pps = 1'b0;
    logic        i_ld_step = 1'b0;
    logic [63:0] i_step_val = 64'd0;
    logic        o_lcl_pps, o_err_stb, o_locked;
    logic [63:0] o_count, o_step, o_err;

    gps_pps_tracker #(
        .RW(64), .DEFAULT_STEP(STEP0), .ALPHA_SHIFT(A_SH), .BETA_SHIFT(B_SH),
        .LOCK_THRESH(THRESH), .LOCK_COUNT(LCNT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_gps_pps(i_gps_pps),
        .i_ld_step(i_ld_step), .i_step_val(i_step_val),
        .o_lcl_pps(o_lcl_pps), .o_count(o_count), .o_step(o_step),
        .o_err(o_err), .o_err_stb(o_err_stb), .o_locked(o_locked)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rises[$];
    int e0;

    // Reference model state: the values each output should hold in the current cycle.
    logic [63:0] m_count = 64'd0, m_step = STEP0, m_err = 64'd0;
    logic        m_stb = 1'b0, m_pps = 1'b0, m_locked = 1'b0;
    logic        m_track = 1'b0, m_pend = 1'b0;
    int          m_good = 0, m_miss = 0;
    logic [4:1]  h = 4'b0000;   // h[k] = GPS level k cycles ago, as seen after reset

    logic [194:0] dut_v, mod_v;
    assign dut_v = {o_count, o_step, o_err, o_err_stb, o_lcl_pps, o_locked};
    assign mod_v = {m_count, m_step, m_err, m_stb, m_pps, m_locked};

    task automatic model_update();
        logic signed [127:0] e, ca, cb, tot, mag;
        logic [63:0] old_count, old_step;
        logic        edge_now, carry, old_pend;
        if (i_reset) begin
            m_count = 64'd0; m_step = STEP0; m_err = 64'd0;
            m_stb = 1'b0; m_pps = 1'b0; m_locked = 1'b0;
            m_good = 0; m_miss = 0; m_track = 1'b0; m_pend = 1'b0; h = 4'b0000;
            return;
        end
        edge_now  = h[3] & ~h[4] & ~m_pend;
        h         = {h[3:1], i_gps_pps};
        old_count = m_count;
        old_step  = m_step;
        old_pend  = m_pend;
        e   = {{64{m_err[63]}}, m_err};
        ca  = old_pend ? (e >>> A_SH) : 128'sd0;
        tot = $signed({64'd0, old_count}) + $signed({64'd0, old_step}) + ca;
        carry = (tot >= TWO64);
        m_count = tot[63:0];
        m_pps   = carry;
        m_stb   = 1'b0;
        m_pend  = 1'b0;
        if (!m_track && edge_now) begin
            m_count = old_step; m_pps = 1'b1; m_track = 1'b1;
            m_miss = 0; m_good = 0; m_locked = 1'b0;
        end else if (m_track && edge_now) begin
            m_err = 64'd0 - old_count; m_stb = 1'b1; m_pend = 1'b1; m_miss = 0;
        end else if (m_track && carry) begin
            m_miss++;
            if (m_miss >= 2) begin
                m_track = 1'b0; m_good = 0; m_locked = 1'b0;
            end
        end
        if (old_pend) begin
            cb = e >>> B_SH;
            m_step = old_step + cb[63:0];
            mag = (e < 0) ? -e : e;
            if (mag < $signed({64'd0, THRESH})) m_good = (m_good < LCNT) ? m_good + 1 : LCNT;
            else m_good = 0;
            m_locked = (m_good == LCNT);
        end
        if (i_ld_step) begin
            m_step = i_step_val; m_good = 0; m_locked = 1'b0;
        end
    endtask

    task automatic set_gps();
        i_gps_pps = 1'b0;
        foreach (rises[k]) if (cyc >= rises[k] && cyc < rises[k] + 8) i_gps_pps = 1'b1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_update();
        #1;
        cyc++;
        set_gps();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) begin
            tick();
            vectors++;
            if (dut_v !== {64'd0, STEP0, 64'd0, 3'b000}) begin
                miscompares++;
                $display("FAIL reset_values got=%h expected=%h", dut_v, {64'd0, STEP0, 64'd0, 3'b000});
            end
        end
        i_reset = 1'b0;
        cyc = 0;
        set_gps();
    endtask

    task automatic test_free_run();
        logic [63:0] ek;
        for (int k = 1; k <= 40; k++) begin
            tick();
            ek = 64'(k) << 60;
            vectors++;
            if ({o_count, o_step, o_lcl_pps, o_locked, o_err_stb} !== {ek, STEP0, (k % 16 == 0), 2'b00}) begin
                miscompares++;
                $display("FAIL free_run k=%0d count=%h pps=%b expected count=%h pps=%b", k, o_count, o_lcl_pps, ek, (k % 16 == 0));
            end
            vectors++;
            if (dut_v !== mod_v) begin
                miscompares++;
                $display("FAIL free_run_model cyc=%0d got=%h expected=%h", cyc, dut_v, mod_v);
            end
        end
    endtask

    task automatic test_acquire();
        int r;
        r = cyc + 2;
        e0 = r + 3;
        rises.push_back(r);
        while (cyc < e0 + 1) begin
            tick();
            vectors++;
            if (dut_v !== mod_v) begin
                miscompares++;
                $display("FAIL acquire_model cyc=%0d got=%h expected=%h", cyc, dut_v, mod_v);
            end
        end
        vectors++;
        if ({o_count, o_lcl_pps, o_err_stb} !== {STEP0, 2'b10}) begin
            miscompares++;
            $display("FAIL acquire_align count=%h pps=%b stb=%b expected count=%h pps=1 stb=0", o_count, o_lcl_pps, o_err_stb, STEP0);
        end
    endtask

    task automatic test_lock();
        for (int k = 1; k <= 4; k++) rises.push_back(e0 - 3 + 16 * k);
        rises.push_back(e0 - 3 + 84);
        while (cyc < e0 + 90) begin
            tick();
            vectors++;
            if (dut_v !== mod_v) begin
                miscompares++;
                $display("FAIL lock_model cyc=%0d got=%h expected=%h", cyc, dut_v, mod_v);
            end
            if (cyc == e0 + 65 || cyc == e0 + 66 || cyc == e0 + 85 || cyc == e0 + 86) begin
                vectors++;
                if (o_locked !== (cyc == e0 + 66 || cyc == e0 + 85)) begin
                    miscompares++;
                    $display("FAIL lock_timing cyc=%0d locked=%b expected=%b", cyc - e0, o_locked, (cyc == e0 + 66 || cyc == e0 + 85));
                end
            end
            if (cyc == e0 + 85) begin
                vectors++;
                if ({o_err, o_err_stb} !== {64'hC000_0000_0000_0000, 1'b1}) begin
                    miscompares++;
                    $display("FAIL offset_err err=%h stb=%b expected err=c000000000000000 stb=1", o_err, o_err_stb);
                end
            end
        end
    endtask

    task automatic test_holdover();
        int r;
        repeat (60) begin
            tick();
            vectors++;
            if (dut_v !== mod_v) begin
                miscompares++;
                $display("FAIL holdover_model cyc=%0d got=%h expected=%h", cyc, dut_v, mod_v);
            end
        end
        vectors++;
        if ({o_step, o_locked} !== {64'h0FFF_C000_0000_0000, 1'b0}) begin
            miscompares++;
            $display("FAIL holdover_step step=%h locked=%b expected step=0fffc00000000000 locked=0", o_step, o_locked);
        end
        r = cyc + 1;
        rises.push_back(r);
        while (cyc < r + 4) tick();
        vectors++;
        if ({o_count, o_lcl_pps, o_err_stb} !== {64'h0FFF_C000_0000_0000, 2'b10}) begin
            miscompares++;
            $display("FAIL reacquire count=%h pps=%b stb=%b expected count=0fffc00000000000 pps=1 stb=0", o_count, o_lcl_pps, o_err_stb);
        end
    endtask

    task automatic test_ld_step();
        int r;
        r = cyc + 5;
        rises.push_back(r);
        while (cyc < r + 4) begin
            tick();
            vectors++;
            if (dut_v !== mod_v) begin
                miscompares++;
                $display("FAIL ld_step_model cyc=%0d got=%h expected=%h", cyc, dut_v, mod_v);
            end
        end
        vectors++;
        if (o_err_stb !== 1'b1) begin
            miscompares++;
            $display("FAIL ld_step_pending stb=%b expected 1", o_err_stb);
        end
        i_ld_step = 1'b1;
        i_step_val = 64'h0800_0000_0000_0000;
        tick();
        i_ld_step = 1'b0;
        vectors++;
        if ({o_step, o_locked} !== {64'h0800_0000_0000_0000, 1'b0}) begin
            miscompares++;
            $display("FAIL ld_step_override step=%h locked=%b expected step=0800000000000000 locked=0", o_step, o_locked);
        end
        vectors++;
        if (dut_v !== mod_v) begin
            miscompares++;
            $display("FAIL ld_step_after cyc=%0d got=%h expected=%h", cyc, dut_v, mod_v);
        end
    endtask

    task automatic test_reset_mid();
        int r;
        r = cyc + 7;
        rises.push_back(r);
        while (cyc < r + 4) tick();
        vectors++;
        if (o_err_stb !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_pending stb=%b expected 1", o_err_stb);
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        vectors++;
        if (dut_v !== {64'd0, STEP0, 64'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_mid_values got=%h expected=%h", dut_v, {64'd0, STEP0, 64'd0, 3'b000});
        end
        tick();
        vectors++;
        if ({o_count, o_step, o_err_stb} !== {STEP0, STEP0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_no_corr count=%h step=%h stb=%b expected count=%h step=%h stb=0", o_count, o_step, o_err_stb, STEP0, STEP0);
        end
        repeat (20) begin
            tick();
            vectors++;
            if (dut_v !== mod_v) begin
                miscompares++;
                $display("FAIL reset_mid_model cyc=%0d got=%h expected=%h", cyc, dut_v, mod_v);
            end
        end
    endtask

    task automatic test_random();
        int gap, r, ld_at, stop;
        logic do_ld;
        logic [63:0] sv;
        for (int round = 0; round < 30; round++) begin
            gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 60)) : int'($urandom_range(10, 24));
            r     = cyc + gap;
            rises.push_back(r);
            do_ld = ($urandom_range(0, 3) == 0);
            ld_at = cyc + int'($urandom_range(0, gap + 4));
            stop  = r + 3 + int'($urandom_range(0, 6));
            if ($urandom_range(0, 4) == 0) sv = {$urandom, $urandom};
            else sv = STEP0 + {{40{1'b0}}, 24'($urandom)} - 64'h0000_0000_0080_0000;
            while (cyc < stop) begin
                i_ld_step  = do_ld && (cyc == ld_at);
                i_step_val = sv;
                tick();
                i_ld_step = 1'b0;
                vectors++;
                if (dut_v !== mod_v) begin
                    miscompares++;
                    $display("FAIL random_model round=%0d cyc=%0d got=%h expected=%h", round, cyc, dut_v, mod_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_acquire();
        test_lock();
        test_holdover();
        test_ld_step();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gps_pps_tracker.md
Name: gps_pps_tracker

Overview:
- Disciplined local time-of-day core. It runs a 64-bit fractional-second counter, phase-locks it to an external GPS PPS with a second-order (proportional + integral) loop, and emits a local PPS.
- Outputs o_lcl_pps, o_err, o_count and o_step drive the GPS clock test bench's i_lcl_pps, i_err, i_count and i_step.
- The test bench's o_pps drives i_gps_pps here, closing the loop for in-FPGA testing.

Parameters:
- RW, 64, counter/step/error width (bits).
- DEFAULT_STEP, 64'h0000_0034_e3d7_0a3d, reset step, about 2^64/81.2 MHz.
- ALPHA_SHIFT, 8, phase-correction arithmetic right shift.
- BETA_SHIFT, 16, frequency-correction arithmetic right shift.
- LOCK_THRESH, 64'h0010_0000_0000_0000, magnitude below which an error counts as "good".
- LOCK_COUNT, 4, consecutive good errors required to declare lock.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_gps_pps  in  1  asynchronous GPS PPS level.
- i_ld_step  in  1  one-cycle strobe; load i_step_val into the step.
- i_step_val  in  RW  new step value.
- o_lcl_pps  out  1  one-cycle local PPS pulse.
- o_count  out  RW  current fractional-second count.
- o_step  out  RW  current step (count increment per clock).
- o_err  out  RW  last signed phase error.
- o_err_stb  out  1  one-cycle pulse when o_err updates.
- o_locked  out  1  loop locked.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-high on i_reset. A reset mid-operation discards any in-flight edge/update and restores the values below.
- Reset values: o_count=0, o_step=DEFAULT_STEP, o_err=0, o_err_stb=0, o_lcl_pps=0, o_locked=0, state=ACQUIRE, good counter=0, miss counter=0, synchroniser flops=0.
- Input sync: i_gps_pps passes through 2 flip-flops, then rising-edge detect.
  - gps_edge is a 1-cycle internal pulse, asserted 3 cycles after the input rise (cycle E).
  - No latency compensation is applied.
- Free run: every cycle, count <= count + step (mod 2^RW).
  - Carry out of bit RW-1 asserts o_lcl_pps on the next cycle, for 1 cycle.
- States: ACQUIRE and TRACK.
- ACQUIRE, on gps_edge at cycle E:
  - Count becomes step at E+1, treating E as count 0.
  - o_lcl_pps pulses at E+1.
  - No error is reported and step is unchanged.
  - Go to TRACK; clear the miss and good counters.
- TRACK, on gps_edge at cycle E:
  - At E+1: o_err <= 0 - count(E) as 2's-complement signed, and o_err_stb=1.
  - At E+2: count <= count + step + (o_err >>> ALPHA_SHIFT), and step <= step + (o_err >>> BETA_SHIFT). Both use sign-extended shifts with RW-bit wrap-around.
  - Carry detection at E+2 uses the corrected sum; at most one o_lcl_pps per cycle.
- Lock:
  - At E+2, if |o_err| < LOCK_THRESH, good counter += 1, saturating at LOCK_COUNT; o_locked=1 when it reaches LOCK_COUNT.
  - Otherwise good counter=0 and o_locked=0.
  - The most-negative error value counts as not good.
- Miss:
  - In TRACK, each local carry increments the miss counter; a gps_edge clears it.
  - If the miss counter reaches 2, go to ACQUIRE, o_locked=0, good=0. Step is retained (holdover).
- Simultaneous events:
  - gps_edge and a carry in the same cycle: the carry still produces o_lcl_pps; the miss counter clears (edge wins); the error uses count(E), the post-add value.
  - A gps_edge arriving at E+1 while a correction is pending is ignored.
  - i_ld_step overrides the loop's step update in the same cycle and also clears good/o_locked.

Test Plan:
- Reset with DEFAULT_STEP=2^60, no GPS -> o_count 0,2^60,...; o_lcl_pps pulses every 16 cycles; o_locked=0; state stays ACQUIRE.
- ACQUIRE, i_gps_pps rises at cycle 10 -> E=13; o_count=2^60 at 14; o_lcl_pps pulse at 14; no o_err_stb.
- TRACK, edge when count(E)=2^58 -> o_err=-2^58 (0xFC00..0) with o_err_stb at E+1.
  - At E+2 with ALPHA_SHIFT=8, BETA_SHIFT=16: count = count(E+1) + step - 2^50, and step = 2^60 - 2^42.
- GPS edges exactly every 16 cycles, aligned to carry, error 0 -> o_locked rises at the 4th tracked edge's E+2.
  - One edge offset by +4 cycles (|err| large) -> o_locked drops at that edge's E+2.
- GPS removed in TRACK -> after 2 local carries, state returns to ACQUIRE, o_locked=0, o_step unchanged.
- i_ld_step with i_step_val=2^59 in the same cycle as a pending correction -> o_step=2^59 next cycle; o_locked=0.
- Assert i_reset at E+1 -> next cycle all outputs at reset values; no correction applied.
